npu_operand_streamer: RTL and testbench

NPU_OPERAND_STREAMER -- requirements
Module: npu_operand_streamer

---
 rtl/npu_operand_streamer.sv | 169 ++++++++++++++++
 tb/tb_npu_operand_streamer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_operand_streamer.sv
// Purpose: buffers up to DEPTH {data, weight} operand pairs, streams them to the NPU on start, then waits for the NPU result.
// Latency: first valid beat is one cycle after start is sampled; result/result_valid appear one cycle after done is sampled in WAIT.
// Backpressure: none toward the NPU (beats are back-to-back); loads are refused while full or while not IDLE; WAIT aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst_n          - single clock, asynchronous active-low reset
//   ld_en/ld_data/ld_weight - push one operand pair (IDLE only, not full)
//   start               - begin streaming buffered pairs (IDLE only, count>0)
//   in_data/weight/valid - registered operand beats to the NPU
//   out_data/done       - NPU result, sampled only in WAIT
//   count/full          - buffer occupancy, from registered count only
//   busy                - FSM is not IDLE
//   result/result_valid - last captured NPU result and its one-cycle update pulse
//   timeout             - sticky abort flag, cleared by the next accepted start
module npu_operand_streamer #(
   parameter int BANDWIDTH = 32,
   parameter int DEPTH     = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ld_en,
   input  logic [BANDWIDTH-1:0]     ld_data,
   input  logic [31:0]              ld_weight,
   input  logic                     start,
   output logic [BANDWIDTH-1:0]     in_data,
   output logic [31:0]              weight,
   output logic                     valid,
   input  logic [31:0]              out_data,
   input  logic                     done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     busy,
   output logic [31:0]              result,
   output logic                     result_valid,
   output logic                     timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int EW = BANDWIDTH + 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   // Operand buffer: no reset, contents are only ever read below count.
   logic [EW-1:0] mem_q [DEPTH];

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        rd_idx_q, rd_idx_d;
   logic [TW-1:0]        wait_cnt_q, wait_cnt_d;
   logic                 valid_q, valid_d;
   logic [BANDWIDTH-1:0] in_data_q, in_data_d;
   logic [31:0]          weight_q, weight_d;
   logic [31:0]          result_q, result_d;
   logic                 result_valid_q, result_valid_d;
   logic                 timeout_q, timeout_d;
   logic                 wr_en;
   logic [EW-1:0]        rd_entry;

   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign busy     = (state_q != S_IDLE);
   assign valid    = valid_q;
   assign in_data  = in_data_q;
   assign weight   = weight_q;
   assign result   = result_q;
   assign result_valid = result_valid_q;
   assign timeout  = timeout_q;

   assign rd_entry = mem_q[rd_idx_q[AW-1:0]];

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      rd_idx_d       = rd_idx_q;
      wait_cnt_d     = wait_cnt_q;
      valid_d        = 1'b0;
      in_data_d      = '0;
      weight_d       = '0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      timeout_d      = timeout_q;
      wr_en          = 1'b0;

      case (state_q)
         S_IDLE: begin
            // start wins over a same-cycle load; entry 0 goes out immediately
            // so the first beat lands in the cycle after start is sampled.
            if (start && (count_q != '0)) begin
               state_d   = S_STREAM;
               timeout_d = 1'b0;
               valid_d   = 1'b1;
               {in_data_d, weight_d} = mem_q[0];
               rd_idx_d  = CW'(1);
            end else if (ld_en && !full) begin
               wr_en   = 1'b1;
               count_d = count_q + CW'(1);
            end
         end
         S_STREAM: begin
            if (rd_idx_q == count_q) begin
               state_d    = S_WAIT;
               wait_cnt_d = '0;
            end else begin
               valid_d  = 1'b1;
               {in_data_d, weight_d} = rd_entry;
               rd_idx_d = rd_idx_q + CW'(1);
            end
         end
         S_WAIT: begin
            if (done) begin
               result_d       = out_data;
               result_valid_d = 1'b1;
               count_d        = '0;
               state_d        = S_IDLE;
            end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
               // This was the TIMEOUT-th WAIT cycle without done.
               timeout_d = 1'b1;
               count_d   = '0;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         count_q        <= '0;
         rd_idx_q       <= '0;
         wait_cnt_q     <= '0;
         valid_q        <= 1'b0;
         in_data_q      <= '0;
         weight_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         rd_idx_q       <= rd_idx_d;
         wait_cnt_q     <= wait_cnt_d;
         valid_q        <= valid_d;
         in_data_q      <= in_data_d;
         weight_q       <= weight_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         timeout_q      <= timeout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[count_q[AW-1:0]] <= {ld_data, ld_weight};
      end
   end

endmodule

// File: tb/tb_npu_operand_streamer.sv
// Bench for npu_operand_streamer: queue-based reference model, per-cycle compare, directed plus random stimulus.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
// Directed scenarios pin the model with literal expectations before a long random run.
module tb_npu_operand_streamer;

   localparam int BW      = 32;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ld_en = 1'b0;
   logic [BW-1:0] ld_data = '0;
   logic [31:0]   ld_weight = '0;
   logic          start = 1'b0;
   logic [BW-1:0] in_data;
   logic [31:0]   weight;
   logic          valid;
   logic [31:0]   out_data = '0;
   logic          done = 1'b0;
   logic [3:0]    count;
   logic          full;
   logic          busy;
   logic [31:0]   result;
   logic          result_valid;
   logic          timeout;

   int n_tests = 0;
   int n_fail  = 0;

   npu_operand_streamer #(.BANDWIDTH(BW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_data(ld_data), .ld_weight(ld_weight),
      .start(start), .in_data(in_data), .weight(weight), .valid(valid),
      .out_data(out_data), .done(done), .count(count), .full(full), .busy(busy),
      .result(result), .result_valid(result_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // pairs: buffered entries; beats: entries still to be shown on the NPU side
   // (head is the one visible now); waiting/age: result wait and its length.
   logic [63:0] pairs[$];
   logic [63:0] beats[$];
   bit          waiting = 0;
   int          age = 0;
   logic [31:0] m_result = '0;
   bit          m_rv = 0;
   bit          m_to = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            pairs.delete(); beats.delete();
            waiting = 0; age = 0; m_result = '0; m_rv = 0; m_to = 0;
         end else begin
            m_rv = 0;
            if (beats.size() > 0) begin
               void'(beats.pop_front());
               if (beats.size() == 0) begin
                  waiting = 1;
                  age = 1;
               end
            end else if (waiting) begin
               if (done) begin
                  m_result = out_data; m_rv = 1; pairs.delete(); waiting = 0;
               end else if (age == TIMEOUT) begin
                  m_to = 1; pairs.delete(); waiting = 0;
               end else begin
                  age++;
               end
            end else if (start && pairs.size() > 0) begin
               beats = pairs;
               m_to = 0;
            end else if (ld_en && pairs.size() < DEPTH) begin
               pairs.push_back({ld_data, ld_weight});
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         begin
            logic [63:0] e_pair;
            bit e_valid;
            e_valid = beats.size() > 0;
            e_pair  = e_valid ? beats[0] : 64'd0;
            chk("valid",        {63'd0, valid},        {63'd0, e_valid});
            chk("in_data",      {32'd0, in_data},      {32'd0, e_pair[63:32]});
            chk("weight",       {32'd0, weight},       {32'd0, e_pair[31:0]});
            chk("busy",         {63'd0, busy},         {63'd0, (e_valid || waiting)});
            chk("count",        {60'd0, count},        64'(pairs.size()));
            chk("full",         {63'd0, full},         {63'd0, (pairs.size() == DEPTH)});
            chk("result",       {32'd0, result},       {32'd0, m_result});
            chk("result_valid", {63'd0, result_valid}, {63'd0, m_rv});
            chk("timeout",      {63'd0, timeout},      {63'd0, m_to});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [31:0] d, input logic [31:0] w);
      ld_en = 1'b1; ld_data = d; ld_weight = w;
      step();
      ld_en = 1'b0;
   endtask

   // Start, let n beats go by, then present done with the given value.
   task automatic run_stream(input int n, input logic [31:0] dval);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (n) step();
      done = 1'b1; out_data = dval;
      step();
      done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      chk("reset_count", {60'd0, count}, 64'd0);
      chk("reset_valid", {63'd0, valid}, 64'd0);
      rst_n = 1'b1;
      step();

      // Eight pairs (1,2)..(15,16), streamed in order, result 0x2E8.
      for (int i = 0; i < 8; i++) load(32'(2 * i + 1), 32'(2 * i + 2));
      chk("load8_full", {63'd0, full}, 64'd1);
      chk("load8_count", {60'd0, count}, 64'd8);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("beat_valid", {63'd0, valid}, 64'd1);
         chk("beat_data", {32'd0, in_data}, 64'(2 * i + 1));
         chk("beat_weight", {32'd0, weight}, 64'(2 * i + 2));
         step();
      end
      chk("wait_valid_low", {63'd0, valid}, 64'd0);
      chk("wait_busy", {63'd0, busy}, 64'd1);
      done = 1'b1; out_data = 32'h0000_02E8;
      step();
      done = 1'b0;
      chk("result_2e8", {32'd0, result}, 64'h2E8);
      chk("result_valid_pulse", {63'd0, result_valid}, 64'd1);
      chk("count_cleared", {60'd0, count}, 64'd0);
      step();
      chk("result_valid_one_cycle", {63'd0, result_valid}, 64'd0);

      // Nine loads into eight entries: the ninth is dropped.
      for (int i = 0; i < 9; i++) load(32'(100 + i), 32'(200 + i));
      chk("load9_count", {60'd0, count}, 64'd8);
      chk("load9_full", {63'd0, full}, 64'd1);
      run_stream(8, 32'h0000_1234);
      chk("result_1234", {32'd0, result}, 64'h1234);

      // Start with an empty buffer does nothing.
      start = 1'b1;
      repeat (3) begin
         step();
         chk("empty_start_busy", {63'd0, busy}, 64'd0);
         chk("empty_start_valid", {63'd0, valid}, 64'd0);
      end
      start = 1'b0;

      // Three pairs, no done: abort after TIMEOUT WAIT cycles.
      for (int i = 0; i < 3; i++) load(32'(7 + i), 32'(70 + i));
      start = 1'b1; ld_en = 1'b1; ld_data = 32'hAAAA; ld_weight = 32'hBBBB;
      step();
      start = 1'b0; ld_en = 1'b0;
      repeat (3 + TIMEOUT - 1) step();
      chk("pre_timeout_flag", {63'd0, timeout}, 64'd0);
      chk("pre_timeout_busy", {63'd0, busy}, 64'd1);
      step();
      chk("timeout_set", {63'd0, timeout}, 64'd1);
      chk("timeout_count", {60'd0, count}, 64'd0);
      chk("timeout_result_kept", {32'd0, result}, 64'h1234);
      chk("timeout_no_rv", {63'd0, result_valid}, 64'd0);
      load(32'h55, 32'h66);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("timeout_cleared", {63'd0, timeout}, 64'd0);
      step();
      done = 1'b1; out_data = 32'h77;
      step();
      done = 1'b0;
      chk("result_77", {32'd0, result}, 64'h77);

      // done during STREAM is ignored; only the WAIT done counts.
      for (int i = 0; i < 4; i++) load(32'(40 + i), 32'(50 + i));
      start = 1'b1;
      step();
      start = 1'b0;
      done = 1'b1; out_data = 32'hDEAD;
      repeat (4) step();
      done = 1'b0;
      chk("stream_done_ignored", {32'd0, result}, 64'h77);
      repeat (2) step();
      done = 1'b1; out_data = 32'hBEEF;
      step();
      done = 1'b0;
      chk("result_beef", {32'd0, result}, 64'hBEEF);

      // Reset during the third beat of eight.
      for (int i = 0; i < 8; i++) load(32'(300 + i), 32'(400 + i));
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("third_beat_data", {32'd0, in_data}, 64'd302);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_in_data", {32'd0, in_data}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_count", {60'd0, count}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
      step();
      rst_n = 1'b1;
      repeat (10) begin
         step();
         chk("post_rst_no_valid", {63'd0, valid}, 64'd0);
      end

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         ld_en     = ($urandom_range(0, 2) != 0);
         ld_data   = $urandom;
         ld_weight = $urandom;
         start     = ($urandom_range(0, 9) == 0);
         done      = ($urandom_range(0, 19) == 0);
         out_data  = $urandom;
         rst_n     = ($urandom_range(0, 499) != 0);
         step();
      end
      ld_en = 1'b0; start = 1'b0; done = 1'b0; rst_n = 1'b1;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
